// File: rtl/riscv_apu_disp_multi_if.sv
// riscv_apu_disp_multi_if: request/grant/result handshake between the dispatcher and the shared APU interconnect
interface riscv_apu_disp_multi_if;
  logic req;
  logic ready;
  logic gnt;
  logic valid;
  modport master (output req, ready, input gnt, valid);
  modport slave (input req, ready, output gnt, valid);
endinterface

// File: rtl/riscv_apu_disp_multi.sv
// riscv_apu_disp_multi: APU dispatcher tracking DEPTH in-order multicycle ops with hazard/stall flags
// RISCV_APU_DISP_PERF_EN adds a saturating stall-cycle counter on perf_cnt_o
module riscv_apu_disp_multi #(
  parameter int DEPTH  = 2,
  parameter int AW     = 6,
  parameter int NREAD  = 3,
  parameter int NWRITE = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           enable_i,
  input  logic [1:0]                     apu_lat_i,
  input  logic [AW-1:0]                  apu_waddr_i,
  output logic [AW-1:0]                  apu_waddr_o,
  output logic                           apu_multicycle_o,
  output logic                           apu_singlecycle_o,
  output logic                           active_o,
  output logic [$clog2(DEPTH+1)-1:0]     outstanding_o,
  output logic                           stall_o,
  input  logic [NREAD-1:0][AW-1:0]       read_regs_i,
  input  logic [NREAD-1:0]               read_regs_valid_i,
  output logic                           read_dep_o,
  input  logic [NWRITE-1:0][AW-1:0]      write_regs_i,
  input  logic [NWRITE-1:0]              write_regs_valid_i,
  output logic                           write_dep_o,
  output logic                           perf_type_o,
  output logic                           perf_cont_o,
  output logic [31:0]                    perf_cnt_o,
  riscv_apu_disp_multi_if.master         apu_master
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);
  logic [DEPTH-1:0][AW-1:0] r_addr;
  logic [DEPTH-1:0]         r_vld;
  logic [PW-1:0]            r_head, r_tail;
  logic [CW-1:0]            r_cnt;
  logic [1:0]               r_lat;
  logic [DEPTH-1:0]         w_live;
  logic w_active, w_stall_full, w_stall_type, w_stall_nack;
  logic w_valid_req, w_accepted, w_pop, w_returned_req, w_push, w_req_live;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction
  assign w_active       = r_cnt != '0;
  assign w_stall_full   = r_cnt == CW'(DEPTH);
  assign w_stall_type   = enable_i & w_active &
                          (apu_lat_i == 2'd1 | (apu_lat_i == 2'd2 & r_lat == 2'd3) | apu_lat_i == 2'd3);
  assign w_valid_req    = enable_i & ~w_stall_full & ~w_stall_type;
  assign w_stall_nack   = w_valid_req & ~apu_master.gnt;
  assign w_accepted     = w_valid_req & apu_master.gnt;
  assign w_pop          = apu_master.valid & w_active;
  // an empty queue means a returning result can only belong to the request issued this cycle
  assign w_returned_req = apu_master.valid & ~w_active & w_valid_req;
  assign w_push         = w_accepted & ~w_returned_req;
  assign w_req_live     = w_valid_req & ~w_returned_req;
  assign apu_waddr_o       = w_pop ? r_addr[r_head] : w_returned_req ? apu_waddr_i : '0;
  assign apu_multicycle_o  = r_lat == 2'd3;
  assign active_o          = w_active;
  assign apu_singlecycle_o = ~w_active;
  assign outstanding_o     = r_cnt;
  assign stall_o           = w_stall_full | w_stall_type | w_stall_nack;
  assign perf_type_o       = w_stall_type;
  assign perf_cont_o       = w_stall_nack;
  assign apu_master.req    = w_valid_req;
  assign apu_master.ready  = 1'b1;
  always_comb begin
    w_live = r_vld;
    if (w_pop) w_live[r_head] = 1'b0;
  end
  always_comb begin
    read_dep_o  = 1'b0;
    write_dep_o = 1'b0;
    for (int i = 0; i < NREAD; i++) begin
      read_dep_o |= w_req_live & read_regs_valid_i[i] & (read_regs_i[i] == apu_waddr_i);
      for (int j = 0; j < DEPTH; j++)
        read_dep_o |= w_live[j] & read_regs_valid_i[i] & (read_regs_i[i] == r_addr[j]);
    end
    for (int i = 0; i < NWRITE; i++) begin
      write_dep_o |= w_req_live & write_regs_valid_i[i] & (write_regs_i[i] == apu_waddr_i);
      for (int j = 0; j < DEPTH; j++)
        write_dep_o |= w_live[j] & write_regs_valid_i[i] & (write_regs_i[i] == r_addr[j]);
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_addr <= '0;
      r_vld  <= '0;
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= '0;
      r_lat  <= '0;
    end else begin
      if (w_valid_req) r_lat <= apu_lat_i;
      if (w_push) begin
        r_addr[r_tail] <= apu_waddr_i;
        r_vld[r_tail]  <= 1'b1;
        r_tail         <= nxt(r_tail);
      end
      if (w_pop) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= nxt(r_head);
      end
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end
`ifdef RISCV_APU_DISP_PERF_EN
  logic [31:0] r_perf_cnt;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_perf_cnt <= '0;
    else if (stall_o && r_perf_cnt != '1) r_perf_cnt <= r_perf_cnt + 1'b1;
  end
  assign perf_cnt_o = r_perf_cnt;
`else
  assign perf_cnt_o = '0;
`endif
  // a result with nothing outstanding and no issuing request has no destination
  assert property (@(posedge clk_i) disable iff (!rst_ni) apu_master.valid |-> (w_active | w_valid_req));
endmodule
